// File: rtl/sram_buffer_pkg.sv
// Shared types and helpers for the multi-channel SRAM buffer.
package sram_buffer_pkg;

   // Channel index width; a single channel still needs a one-bit index port.
   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

   // Registered read-port status: bit 0 is rd_dvalid, bit 1 is rd_err.
   typedef enum logic [1:0] {
      RD_IDLE = 2'b00,
      RD_DATA = 2'b01,
      RD_ERR  = 2'b10
   } rd_status_e;

endpackage

// File: rtl/sram_buffer_ch_ctrl.sv
// Per-channel FIFO bookkeeping: pointers, occupancy and status flags.
// push_i/pop_i are already-qualified strobes; flush_i overrides both.
module sram_buffer_ch_ctrl #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AF_LVL = 12,
   localparam int unsigned PtrW  = $clog2(DEPTH),
   localparam int unsigned CntW  = PtrW + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            push_i,
   input  logic            pop_i,
   output logic [PtrW-1:0] wr_ptr_o,
   output logic [PtrW-1:0] rd_ptr_o,
   output logic [CntW-1:0] count_o,
   output logic            empty_o,
   output logic            full_o,
   output logic            almost_full_o
);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   // Next-state: advance pointers on accepted ops, net count change, flush wins.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Flags come from registered state only.
   always_comb begin
      empty_o       = (count_q == '0);
      full_o        = (count_q == CntW'(DEPTH));
      almost_full_o = (count_q >= CntW'(AF_LVL));
   end

   assign wr_ptr_o = wr_ptr_q;
   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;

endmodule

// File: rtl/sram_buffer_mc.sv
// Multi-channel SRAM buffer: NUM_CH circular FIFOs sharing one memory,
// one write and one read per cycle, read data one cycle after acceptance.
// Optional per-channel dropped-write counters: SRAM_BUFFER_MC_OVF_CNT_EN.
module sram_buffer_mc
   import sram_buffer_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned AF_LVL  = 12,
   localparam int unsigned CH_W   = ch_width(NUM_CH),
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [CH_W-1:0]         wr_ch,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_ready,
   input  logic                    rd_en,
   input  logic [CH_W-1:0]         rd_ch,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_dvalid,
   output logic                    rd_err,
   output logic [NUM_CH-1:0]       empty,
   output logic [NUM_CH-1:0]       full,
   output logic [NUM_CH-1:0]       almost_full,
`ifdef SRAM_BUFFER_MC_OVF_CNT_EN
   output logic [NUM_CH*8-1:0]     ovf_cnt,
`endif
   output logic [NUM_CH*CNT_W-1:0] count
);

   logic [DATA_W-1:0] mem_q [NUM_CH*DEPTH];

   logic [PTR_W-1:0] wr_ptr_w [NUM_CH];
   logic [PTR_W-1:0] rd_ptr_w [NUM_CH];
   logic [CNT_W-1:0] count_w  [NUM_CH];

   logic [NUM_CH-1:0] wr_hit, rd_hit, push, pop;
   logic [PTR_W-1:0]  wr_ptr_sel, rd_ptr_sel;
   logic              wr_full_sel, rd_empty_sel;
   logic              wr_accept, rd_accept, rd_reject;

   rd_status_e        rd_status_q, rd_status_d;
   logic [DATA_W-1:0] rd_data_q;

   // Channel decode; an out-of-range index selects nothing and looks full/empty.
   always_comb begin
      wr_hit       = '0;
      rd_hit       = '0;
      wr_ptr_sel   = '0;
      rd_ptr_sel   = '0;
      wr_full_sel  = 1'b1;
      rd_empty_sel = 1'b1;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         wr_hit[i] = (32'(wr_ch) == 32'(i));
         rd_hit[i] = (32'(rd_ch) == 32'(i));
         if (wr_hit[i]) begin
            wr_ptr_sel  = wr_ptr_w[i];
            wr_full_sel = full[i];
         end
         if (rd_hit[i]) begin
            rd_ptr_sel   = rd_ptr_w[i];
            rd_empty_sel = empty[i];
         end
      end
   end

   assign wr_ready  = !wr_full_sel;
   assign wr_accept = wr_en && !wr_full_sel && !flush;
   assign rd_accept = rd_en && !rd_empty_sel && !flush;
   assign rd_reject = rd_en && rd_empty_sel && !flush;
   assign push      = wr_hit & {NUM_CH{wr_accept}};
   assign pop       = rd_hit & {NUM_CH{rd_accept}};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sram_buffer_ch_ctrl #(
         .DEPTH  (DEPTH),
         .AF_LVL (AF_LVL)
      ) u_ch_ctrl (
         .clk_i         (clk),
         .rst_ni        (n_rst),
         .flush_i       (flush),
         .push_i        (push[g]),
         .pop_i         (pop[g]),
         .wr_ptr_o      (wr_ptr_w[g]),
         .rd_ptr_o      (rd_ptr_w[g]),
         .count_o       (count_w[g]),
         .empty_o       (empty[g]),
         .full_o        (full[g]),
         .almost_full_o (almost_full[g])
      );
      assign count[g*CNT_W +: CNT_W] = count_w[g];
   end

   // Memory write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[{wr_ch, wr_ptr_sel}] <= wr_data;
   end

   // Next read status; a flush cycle never reports an error.
   always_comb begin
      rd_status_d = RD_IDLE;
      if (rd_accept)      rd_status_d = RD_DATA;
      else if (rd_reject) rd_status_d = RD_ERR;
   end

   // Read pipeline register; rd_data holds its value unless a read is accepted.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_status_q <= RD_IDLE;
         rd_data_q   <= '0;
      end else begin
         rd_status_q <= rd_status_d;
         if (rd_accept) rd_data_q <= mem_q[{rd_ch, rd_ptr_sel}];
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_dvalid = rd_status_q[0];
   assign rd_err    = rd_status_q[1];

`ifdef SRAM_BUFFER_MC_OVF_CNT_EN
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ovf
      logic [7:0] ovf_q, ovf_d;
      logic       drop;

      assign drop = wr_en && !flush && wr_hit[g] && full[g];

      // Saturating dropped-write counter, cleared by flush.
      always_comb begin
         ovf_d = ovf_q;
         if (flush)                      ovf_d = '0;
         else if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
      end

      // Counter register.
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) ovf_q <= '0;
         else        ovf_q <= ovf_d;
      end

      assign ovf_cnt[g*8 +: 8] = ovf_q;
   end
`endif

endmodule

// File: tb/tb_sram_buffer_mc.sv
// Directed self-checking bench for sram_buffer_mc (default parameters).
module tb_sram_buffer_mc;
   import sram_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst, flush, wr_en, rd_en;
   logic [1:0]  wr_ch, rd_ch;
   logic [7:0]  wr_data;
   logic        wr_ready, rd_dvalid, rd_err;
   logic [7:0]  rd_data;
   logic [3:0]  empty, full, almost_full;
   logic [19:0] count;
`ifdef SRAM_BUFFER_MC_OVF_CNT_EN
   logic [31:0] ovf_cnt;
`endif

   int total  = 0;
   int passed = 0;

   sram_buffer_mc dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .rd_en       (rd_en),
      .rd_ch       (rd_ch),
      .rd_data     (rd_data),
      .rd_dvalid   (rd_dvalid),
      .rd_err      (rd_err),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
`ifdef SRAM_BUFFER_MC_OVF_CNT_EN
      .ovf_cnt     (ovf_cnt),
`endif
      .count       (count)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] cnt_of(input int ch);
      return count[ch*5 +: 5];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] ch, input logic [7:0] d);
      wr_en = 1'b1; wr_ch = ch; wr_data = d;
   endtask

   initial begin
      n_rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_ch = '0; rd_ch = '0; wr_data = '0;

      // Reset values
      #12;
      check("rst_empty", 32'(empty), 32'hF);
      check("rst_full", 32'(full), 32'h0);
      check("rst_af", 32'(almost_full), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_rdv_err_data", {22'd0, rd_dvalid, rd_err, rd_data}, 32'h0);
      n_rst = 1'b1;

      // Basic write/read on ch1
      wr(2'd1, 8'hA1);
      check("wr_ready_ch1", 32'(wr_ready), 32'h1);
      tick();
      wr_data = 8'hA2;
      tick();
      wr_en = 1'b0;
      check("ch1_count2", 32'(cnt_of(1)), 32'd2);
      check("ch1_not_empty", 32'(empty), 32'hD);
      rd_en = 1'b1; rd_ch = 2'd1;
      tick();
      check("ch1_rd0", {23'd0, rd_dvalid, rd_data}, 32'h1A1);
      tick();
      check("ch1_rd1", {23'd0, rd_dvalid, rd_data}, 32'h1A2);
      rd_en = 1'b0;
      check("ch1_empty_again", 32'(empty[1]), 32'h1);
      tick();
      check("ch1_idle_hold", {23'd0, rd_dvalid, rd_data}, 32'h0A2);

      // Fill ch2 to full, overflow, drain
      for (int i = 0; i < 16; i++) begin
         wr(2'd2, 8'(8'h20 + i));
         tick();
         if (i == 10) check("ch2_af_11", 32'(almost_full[2]), 32'h0);
         if (i == 11) check("ch2_af_12", 32'(almost_full[2]), 32'h1);
      end
      check("ch2_full", 32'(full), 32'h4);
      check("ch2_wr_ready_full", 32'(wr_ready), 32'h0);
      wr_data = 8'hFF;
      tick();
      check("ch2_drop_count", 32'(cnt_of(2)), 32'd16);
`ifdef SRAM_BUFFER_MC_OVF_CNT_EN
      check("ch2_ovf1", 32'(ovf_cnt[23:16]), 32'd1);
`endif
      wr_data = 8'hFE;
      rd_en = 1'b1; rd_ch = 2'd2;
      for (int i = 0; i < 16; i++) begin
         tick();
         wr_en = 1'b0;
         check("ch2_drain", {23'd0, rd_dvalid, rd_data}, 32'h100 | 32'(8'h20 + i));
         if (i == 0) check("ch2_full_rw_count", 32'(cnt_of(2)), 32'd15);
      end
      rd_en = 1'b0;
`ifdef SRAM_BUFFER_MC_OVF_CNT_EN
      check("ch2_ovf2", 32'(ovf_cnt[23:16]), 32'd2);
`endif
      check("all_empty", 32'(empty), 32'hF);

      // Same-cycle write+read on empty ch0
      wr(2'd0, 8'h55);
      rd_en = 1'b1; rd_ch = 2'd0;
      tick();
      check("ch0_empty_rw_err", {22'd0, rd_dvalid, rd_err, rd_data}, 32'h12F);
      check("ch0_empty_rw_count", 32'(cnt_of(0)), 32'd1);
      wr_en = 1'b0;
      tick();
      check("ch0_rd55", {22'd0, rd_dvalid, rd_err, rd_data}, 32'h255);
      rd_en = 1'b0;

      // Interleaved ch0/ch3 traffic
      wr(2'd3, 8'h31); tick();
      wr(2'd0, 8'h01); tick();
      wr(2'd3, 8'h32); rd_en = 1'b1; rd_ch = 2'd3; tick();
      check("ch3_rd31", {23'd0, rd_dvalid, rd_data}, 32'h131);
      wr(2'd0, 8'h02); tick();
      check("ch3_rd32", {23'd0, rd_dvalid, rd_data}, 32'h132);
      wr_en = 1'b0;
      check("cnt_ch0_ch3", {cnt_of(0), cnt_of(3)}, {22'd0, 5'd2, 5'd0});
      rd_ch = 2'd0; tick();
      check("ch0_rd01", 32'(rd_data), 32'h01);
      tick();
      check("ch0_rd02", 32'(rd_data), 32'h02);
      rd_en = 1'b0;

      // Wrap-around on ch1 at occupancy 3
      for (int i = 0; i < 3; i++) begin
         wr(2'd1, 8'(8'h40 + i)); tick();
      end
      rd_en = 1'b1; rd_ch = 2'd1;
      for (int i = 0; i < 20; i++) begin
         wr(2'd1, 8'(8'h43 + i)); tick();
         check("ch1_wrap", {23'd0, rd_dvalid, rd_data}, 32'h100 | 32'(8'h40 + i));
      end
      wr_en = 1'b0;
      check("ch1_wrap_count", 32'(cnt_of(1)), 32'd3);
      tick(); tick(); tick();
      rd_en = 1'b0;
      check("ch1_wrap_last", 32'(rd_data), 32'h56);
      check("ch1_wrap_empty", 32'(empty), 32'hF);

      // Flush with ch0 holding 5 words and a read in flight
      wr(2'd3, 8'h77); tick();
      for (int i = 0; i < 5; i++) begin
         wr(2'd0, 8'(8'h60 + i)); tick();
      end
      wr_en = 1'b0;
      rd_en = 1'b1; rd_ch = 2'd0;
      tick();
      flush = 1'b1; wr(2'd0, 8'hEE);
      check("flush_pending_dvalid", {23'd0, rd_dvalid, rd_data}, 32'h160);
      tick();
      check("flush_status", {22'd0, rd_dvalid, rd_err, rd_data}, 32'h060);
      check("flush_count", 32'(count), 32'h0);
      check("flush_empty", 32'(empty), 32'hF);
`ifdef SRAM_BUFFER_MC_OVF_CNT_EN
      check("flush_ovf", ovf_cnt, 32'h0);
`endif
      flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

      // Asynchronous reset mid-stream
      wr(2'd1, 8'h88); tick();
      wr_en = 1'b0; rd_en = 1'b1; rd_ch = 2'd1; tick();
      check("pre_rst_rd88", {23'd0, rd_dvalid, rd_data}, 32'h188);
      wr(2'd2, 8'h99);
      #2 n_rst = 1'b0;
      #1;
      check("async_rst_rd", {22'd0, rd_dvalid, rd_err, rd_data}, 32'h0);
      check("async_rst_flags", {empty, full, almost_full}, 32'hF00);
      check("async_rst_count", 32'(count), 32'h0);
      wr_en = 1'b0; rd_en = 1'b0;
      #10 n_rst = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sram_buffer_mc.md
Name: sram_buffer_mc

Overview:
- Parametrised multi-channel successor of the single-channel SRAM buffer.
- Holds NUM_CH independent circular FIFOs in one inferred memory of NUM_CH*DEPTH words, each channel owning a fixed region.
- One write port and one read port per cycle, each steered by a channel index.
- Read data has one-cycle SRAM latency. Sits between packet producers and downstream consumers.

Parameters:
- DATA_W, 8, word width in bits
- DEPTH, 16, words per channel; must be a power of two and at least 2
- NUM_CH, 4, number of channels; must be at least 1
- AF_LVL, 12, per-channel almost-full threshold in words

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- flush  in  1  clears all channels
- wr_en  in  1  write request
- wr_ch  in  CH_W  write channel index
- wr_data  in  DATA_W  write data
- wr_ready  out  1  selected write channel not full (combinational)
- rd_en  in  1  read request
- rd_ch  in  CH_W  read channel index
- rd_data  out  DATA_W  read data
- rd_dvalid  out  1  rd_data valid
- rd_err  out  1  read attempted on an empty channel
- empty  out  NUM_CH  per-channel empty flags
- full  out  NUM_CH  per-channel full flags
- almost_full  out  NUM_CH  per-channel flag, count >= AF_LVL
- count  out  NUM_CH*CNT_W  packed per-channel occupancy; channel 0 in the LSBs

Behaviour:
- Clock is clk. Reset is n_rst, asynchronous and active-low.
- Widths: CH_W = max(1, $clog2(NUM_CH)); PTR_W = $clog2(DEPTH); CNT_W = PTR_W+1.
- Reset values:
  - all pointers and counts 0
  - empty all ones; full and almost_full all zeros
  - rd_data 0; rd_dvalid 0; rd_err 0
  - memory contents not reset
- Memory address = {ch, ptr}. Pointers wrap modulo DEPTH naturally.
- Write:
  - Accepted when wr_en && !full[wr_ch] && !flush.
  - Memory written and wr_ptr/count updated on that edge.
  - Write to a full channel is dropped; no state change.
- Read:
  - Accepted when rd_en && !empty[rd_ch] && !flush.
  - rd_data and rd_dvalid=1 appear the next cycle; rd_ptr/count update on the accepting edge.
  - Read of an empty channel: rd_err=1 for one cycle next cycle, rd_dvalid=0, rd_data holds its last value.
- Flags are evaluated on registered state only; no bypass.
  - Write and read to the same empty channel in the same cycle: write accepted, read rejected (rd_err).
  - Write and read to the same full channel in the same cycle: read accepted, write dropped.
  - Write and read to the same non-empty, non-full channel: both accepted; count unchanged.
  - Operations on different channels are fully independent.
- Out-of-range channel index (>= NUM_CH): request ignored; wr_ready=0; a read produces rd_err.
- flush:
  - Clears all pointers and counts on the next edge.
  - Same-cycle wr_en/rd_en are ignored, with no rd_err.
  - A read accepted in the previous cycle still delivers its rd_dvalid.
- count saturates naturally at DEPTH; full = (count == DEPTH).

Optional Feature:
- Macro: SRAM_BUFFER_MC_OVF_CNT_EN.
- When defined:
  - Extra output ovf_cnt (NUM_CH*8 bits), one 8-bit saturating counter per channel.
  - A counter increments on each dropped write (wr_en to a full channel, not during flush) and saturates at 255.
  - Counters are cleared by reset and by flush.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_buffer_pkg holds:
  - function computing CH_W
  - rd_status enum {RD_IDLE, RD_DATA, RD_ERR}, which encodes the registered rd_dvalid/rd_err pair
- Sub-module sram_buffer_ch_ctrl, instantiated NUM_CH times:
  - holds wr_ptr, rd_ptr and count
  - produces empty, full and almost_full from push, pop and flush strobes
- Top level holds the memory array, index decode and read pipeline register.

Test Plan:
- Reset, then write 0xA1, 0xA2 to ch1 and read ch1 twice → rd_data 0xA1 then 0xA2, each one cycle after rd_en; empty[1] returns to 1.
- Fill ch2 with 16 writes → full[2]=1, almost_full[2] set after the 12th write; 17th write dropped (ovf_cnt ch2 = 1 when enabled); reading 16 words returns them in order.
- Same cycle: write ch0 0x55 and read ch0 while empty → rd_err=1 next cycle, count[0]=1; a following read returns 0x55.
- Interleave writes to ch0 and ch3 with reads of ch3 → no cross-channel corruption, counts independent.
- Wrap-around on ch1: 20 write/read pairs at occupancy 3 → data returned in order across the pointer wrap.
- Assert flush with ch0 holding 5 words and a read pending → pending rd_dvalid delivered, then count 0 and empty all ones; drive n_rst low mid-stream → all outputs at reset values immediately.
